// File: rtl/sqrt_nr_engine.sv
// sqrt_nr_engine: iterative non-restoring integer square root.
// Produces one root bit per cycle, then spends one cycle correcting the
// remainder before presenting the result. The start/busy/done handshake
// lets a new operation start in the same cycle that done is high.
// Optional build macro SQRT_ROUND_EN: when defined, result is rounded to
// the nearest integer and saturates at the top of the root range.
// The remainder output always reports the floor remainder.
module sqrt_nr_engine #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   data,
    output logic            busy,
    output logic            done,
    output logic [DW/2-1:0] result,
    output logic [DW/2:0]   remainder
);

    localparam int QW = DW / 2;
    localparam int RW = DW / 2 + 2;
    localparam int CW = $clog2(DW / 2 + 1);

    generate
        if (((DW % 2) != 0) || (DW < 4)) begin : g_bad_dw
            $error("sqrt_nr_engine: DW must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            load_s;
    logic [DW-1:0]   d_r;
    logic [QW-1:0]   q_r;
    logic [RW-1:0]   r_r;
    logic [CW-1:0]   cnt_r;
    logic            busy_r;
    logic            done_r;
    logic [QW-1:0]   result_r;
    logic [QW:0]     remainder_r;

    logic [1:0]      pair_s;
    logic [RW-1:0]   t_s;
    logic [RW-1:0]   r_step_s;
    logic [QW-1:0]   q_step_s;
    logic [RW-1:0]   r_fix_s;
    logic [QW:0]     rem_s;
    logic [QW-1:0]   res_s;
`ifdef SQRT_ROUND_EN
    logic [QW:0]     sum_s;
`endif

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; start only matters when the engine is not busy.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_ITER;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_ITER;
                end
            end
            ST_FIX: begin
                state_nxt_s = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_ITER;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // One non-restoring step plus the final remainder correction and result form.
    always_comb begin
        pair_s = d_r[{cnt_r, 1'b0} +: 2];
        t_s    = {r_r[RW-3:0], pair_s};
        if (!r_r[RW-1]) begin
            r_step_s = t_s - {q_r, 2'b01};
        end else begin
            r_step_s = t_s + {q_r, 2'b11};
        end
        q_step_s = {q_r[QW-2:0], ~r_step_s[RW-1]};
        if (r_r[RW-1]) begin
            r_fix_s = r_r + {1'b0, q_r, 1'b1};
        end else begin
            r_fix_s = r_r;
        end
        rem_s = r_fix_s[QW:0];
`ifdef SQRT_ROUND_EN
        // x.5 is impossible, so remainder > root is exactly "round up".
        sum_s = {1'b0, q_r} + {{QW{1'b0}}, (rem_s > {1'b0, q_r})};
        if (sum_s[QW]) begin
            res_s = {QW{1'b1}};
        end else begin
            res_s = sum_s[QW-1:0];
        end
`else
        res_s = q_r;
`endif
    end

    // Datapath registers and held outputs; result/remainder change only on DONE entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_r         <= {DW{1'b0}};
            q_r         <= {QW{1'b0}};
            r_r         <= {RW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= {QW{1'b0}};
            remainder_r <= {(QW+1){1'b0}};
        end else begin
            busy_r <= (state_nxt_s == ST_ITER) || (state_nxt_s == ST_FIX);
            done_r <= (state_nxt_s == ST_DONE);
            if (load_s) begin
                d_r   <= data;
                q_r   <= {QW{1'b0}};
                r_r   <= {RW{1'b0}};
                cnt_r <= CW'(QW - 1);
            end else begin
                case (state_r)
                    ST_ITER: begin
                        r_r   <= r_step_s;
                        q_r   <= q_step_s;
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                    ST_FIX: begin
                        r_r         <= r_fix_s;
                        result_r    <= res_s;
                        remainder_r <= rem_s;
                    end
                    default: begin
                        r_r <= r_r;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign remainder = remainder_r;

endmodule

// File: doc/sqrt_nr_engine.md
Name: sqrt_nr_engine

Overview:
Parametrised iterative non-restoring integer square root, successor to the 16-bit square-root unit. Owns its add/subtract datapath internally; the old exported adder-operand/op-select interface is removed. Also adds a start/busy/done handshake, back-to-back operation and a held result. Sits beside the multiplier/divider units behind the same operation-select front end.

Parameters:
DW, 16, radicand width in bits; must be even and >= 4 (elaboration error otherwise)
QW, DW/2, localparam; root width
RW, DW/2+2, localparam; internal signed partial-remainder width
CW, $clog2(DW/2+1), localparam; iteration counter width

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request; sampled only in IDLE or DONE
data  in  DW  unsigned radicand; sampled with accepted start
busy  out  1  high in ITER and FIX
done  out  1  one-cycle pulse; result/remainder valid
result  out  QW  floor(sqrt(data)), or rounded if SQRT_ROUND_EN
remainder  out  QW+1  data - floor(sqrt(data))^2, always the floor remainder

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, remainder=0; internal D, Q, R and counter cleared. Applies immediately at any time, including mid-operation. An interrupted operation produces no done and leaves no partial result.
- States: IDLE, ITER, FIX, DONE.
  - IDLE or DONE, start=1: load D=data, Q=0, R=0, cnt=QW-1; next state ITER.
  - DONE, start=0: next state IDLE.
  - ITER: one root bit per cycle. cnt counts down to 0, then next state FIX.
  - FIX: one cycle; next state DONE.
- Start while busy: ignored with no side effect; data is not resampled.
- ITER step, i = cnt:
  - T = (R<<2) | D[2i+1:2i].
  - If R >= 0: R = T - ((Q<<2)|1). Otherwise R = T + ((Q<<2)|3).
  - Then Q = (Q<<1) | ~R_new[RW-1].
  - All arithmetic is RW-bit two's complement; no overflow is possible at this width.
- FIX: if R < 0, R = R + ((Q<<1)|1). Q is unchanged.
- DONE entry: result and remainder are registered from Q and R (remainder = R[QW:0]). done=1 for exactly this one cycle.
- result and remainder hold their values until the next DONE. They do not change on start or while busy.
- Latency: start sampled at edge E0; done is high in the cycle after edge E0+QW+1. For DW=16 that is 10 edges.
- Throughput: a start asserted during the DONE cycle begins the next operation with no IDLE gap, giving one result every QW+2 cycles.
- busy=0 in IDLE and DONE, so busy and done are never high together.
- Bounds: data=0 gives result 0, remainder 0. data=2^DW-1 gives result 2^QW-1, remainder 2^(QW+1)-2, which is the maximum remainder and must fit QW+1 bits.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SQRT_ROUND_EN.
- Defined: result = floor root + (remainder > floor root), i.e. round to nearest (x.5 cannot occur). The compare and add happen at DONE entry with no extra latency. If the floor root is 2^QW-1, the rounded result saturates at 2^QW-1. remainder still reports the floor remainder.
- Undefined: result is the floor root; no compare logic is built.

Test Plan:
- DW=16, reset, then start with data=0 -> done at edge 10 with result=0, remainder=0; busy high for exactly 9 cycles.
- DW=16: data=144 -> 12/0; data=150 -> 12/6; data=65535 -> 255/510. Sweep all 65536 values against a reference model (floor root, and rounded root when the macro is defined).
- SQRT_ROUND_EN defined: data=156 -> result 12, remainder 12; data=157 -> result 13, remainder 13; data=65535 -> result 255 (saturates).
- Back-to-back: start with data=100, then start with data=99 during the DONE cycle -> second done exactly 10 cycles after the first, result=9, remainder=18; first result held until then.
- Start pulsed mid-ITER with data=4 -> ignored; original operation completes with its own result. rst pulsed during ITER -> outputs 0, state IDLE, no done; a new start then completes normally.
- DW=32: data=32'hFFFFFFFF -> result 65535, remainder 131070, latency 18 edges. DW=4: data=15 -> result 3, remainder 6.
